// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared defaults for the operand-fetch stage.
//   DATA_W_DEF  - operand / writeback data width
//   IDX_W_DEF   - register index width
//   SB_ENTRIES  - scoreboard depth for the default index width
package opfetch_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned IDX_W_DEF  = 5;
   localparam int unsigned SB_ENTRIES = 2 ** IDX_W_DEF;

endpackage : opfetch_pkg

// File: rtl/opfetch_scoreboard.sv
// opfetch_scoreboard: one busy bit per architectural register.
//   clk, reset          - clock, async active-low reset (clears all bits)
//   set_en_i/set_idx_i  - mark a register as having a pending write
//   clr_en_i/clr_idx_i  - writeback retires the pending write
//   rs_a_i/rs_b_i/rd_i  - lookup indices
//   busy_*_c_o          - combinational busy lookups
module opfetch_scoreboard
   import opfetch_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_en_i,
   input  logic [IDX_W-1:0] set_idx_i,
   input  logic             clr_en_i,
   input  logic [IDX_W-1:0] clr_idx_i,
   input  logic [IDX_W-1:0] rs_a_i,
   input  logic [IDX_W-1:0] rs_b_i,
   input  logic [IDX_W-1:0] rd_i,
   output logic             busy_a_c_o,
   output logic             busy_b_c_o,
   output logic             busy_rd_c_o
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;

   logic [ENTRIES-1:0] busy_q;
   logic [ENTRIES-1:0] busy_d;

   // Clear applied before set so a same-cycle collision leaves the bit set.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
      if (set_en_i) busy_d[set_idx_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_a_c_o  = busy_q[rs_a_i];
   assign busy_b_c_o  = busy_q[rs_b_i];
   assign busy_rd_c_o = busy_q[rd_i];

endmodule : opfetch_scoreboard

// File: rtl/operand_fetch.sv
// operand_fetch: issues decoded instructions to execute with registered
// operands, reading the register file and stalling on RAW/WAW hazards.
//   clk, reset               - clock, async active-low reset
//   in_*                     - decoded instruction offer (in_ready comb.)
//   rf_r_en_*, rf_r_idx_*    - register file read port (comb.)
//   rf_r_data_*              - read data, valid one cycle after enable
//   wb_valid/wb_idx/wb_data  - writeback bus (also writes the register file)
//   out_*                    - registered operands to execute
// Optional feature: define OPFETCH_WB_BYPASS_EN to let a same-cycle
// writeback satisfy a busy source without a stall.
module operand_fetch
   import opfetch_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IDX_W-1:0]  in_rs_a,
   input  logic [IDX_W-1:0]  in_rs_b,
   input  logic              in_use_a,
   input  logic              in_use_b,
   input  logic [IDX_W-1:0]  in_rd,
   input  logic              in_wr,
   output logic              rf_r_en_a,
   output logic              rf_r_en_b,
   output logic [IDX_W-1:0]  rf_r_idx_a,
   output logic [IDX_W-1:0]  rf_r_idx_b,
   input  logic [DATA_W-1:0] rf_r_data_a,
   input  logic [DATA_W-1:0] rf_r_data_b,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_idx,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op_a,
   output logic [DATA_W-1:0] out_op_b,
   output logic [IDX_W-1:0]  out_rd,
   output logic              out_wr
);

   logic busy_a, busy_b, busy_rd;
   logic src_a_ok, src_b_ok, hazard_ok;
   logic move, accept;

   // READ slot
   logic              rd_v_q, rd_fresh_q;
   logic              rd_use_a_q, rd_use_b_q;
   logic [IDX_W-1:0]  rd_rd_q;
   logic              rd_wr_q;
   logic [DATA_W-1:0] rd_hold_a_q, rd_hold_b_q;

   // OUT slot
   logic              out_v_q;
   logic [DATA_W-1:0] out_op_a_q, out_op_b_q;
   logic [IDX_W-1:0]  out_rd_q;
   logic              out_wr_q;

   logic [DATA_W-1:0] op_a_d, op_b_d;

   opfetch_scoreboard #(.IDX_W(IDX_W)) u_sb (
      .clk         (clk),
      .reset       (reset),
      .set_en_i    (accept & in_wr),
      .set_idx_i   (in_rd),
      .clr_en_i    (wb_valid),
      .clr_idx_i   (wb_idx),
      .rs_a_i      (in_rs_a),
      .rs_b_i      (in_rs_b),
      .rd_i        (in_rd),
      .busy_a_c_o  (busy_a),
      .busy_b_c_o  (busy_b),
      .busy_rd_c_o (busy_rd)
   );

`ifdef OPFETCH_WB_BYPASS_EN
   logic              byp_hit_a, byp_hit_b;
   logic              rd_byp_v_a_q, rd_byp_v_b_q;
   logic [DATA_W-1:0] rd_byp_a_q, rd_byp_b_q;

   assign byp_hit_a = wb_valid & (wb_idx == in_rs_a);
   assign byp_hit_b = wb_valid & (wb_idx == in_rs_b);
   assign src_a_ok  = ~in_use_a | ~busy_a | byp_hit_a;
   assign src_b_ok  = ~in_use_b | ~busy_b | byp_hit_b;

   // Same-cycle writeback: the register file returns the old value, so keep wb_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_byp_v_a_q <= 1'b0;
         rd_byp_v_b_q <= 1'b0;
         rd_byp_a_q   <= '0;
         rd_byp_b_q   <= '0;
      end else if (accept) begin
         rd_byp_v_a_q <= in_use_a & byp_hit_a;
         rd_byp_v_b_q <= in_use_b & byp_hit_b;
         rd_byp_a_q   <= wb_data;
         rd_byp_b_q   <= wb_data;
      end
   end
`else
   logic unused_wb_data;

   assign unused_wb_data = ^wb_data;
   assign src_a_ok       = ~in_use_a | ~busy_a;
   assign src_b_ok       = ~in_use_b | ~busy_b;
`endif

   assign hazard_ok = src_a_ok & src_b_ok & ~(in_wr & busy_rd);
   assign move      = rd_v_q & (~out_v_q | out_ready);
   assign in_ready  = hazard_ok & (~rd_v_q | move);
   assign accept    = in_valid & in_ready;

   assign rf_r_en_a  = accept & in_use_a;
   assign rf_r_en_b  = accept & in_use_b;
   assign rf_r_idx_a = in_rs_a;
   assign rf_r_idx_b = in_rs_b;

   // Operand select: live read data on the first cycle, held copy after a stall.
   always_comb begin
      op_a_d = '0;
      op_b_d = '0;
      if (rd_use_a_q) op_a_d = rd_fresh_q ? rf_r_data_a : rd_hold_a_q;
      if (rd_use_b_q) op_b_d = rd_fresh_q ? rf_r_data_b : rd_hold_b_q;
`ifdef OPFETCH_WB_BYPASS_EN
      if (rd_byp_v_a_q) op_a_d = rd_byp_a_q;
      if (rd_byp_v_b_q) op_b_d = rd_byp_b_q;
`endif
   end

   // READ slot: read data is only guaranteed one cycle, so capture it if OUT is blocked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_v_q      <= 1'b0;
         rd_fresh_q  <= 1'b0;
         rd_use_a_q  <= 1'b0;
         rd_use_b_q  <= 1'b0;
         rd_rd_q     <= '0;
         rd_wr_q     <= 1'b0;
         rd_hold_a_q <= '0;
         rd_hold_b_q <= '0;
      end else begin
         if (accept) begin
            rd_v_q     <= 1'b1;
            rd_fresh_q <= 1'b1;
            rd_use_a_q <= in_use_a;
            rd_use_b_q <= in_use_b;
            rd_rd_q    <= in_rd;
            rd_wr_q    <= in_wr;
         end else if (move) begin
            rd_v_q <= 1'b0;
         end else if (rd_v_q && rd_fresh_q) begin
            rd_fresh_q  <= 1'b0;
            rd_hold_a_q <= rf_r_data_a;
            rd_hold_b_q <= rf_r_data_b;
         end
      end
   end

   // OUT slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_v_q    <= 1'b0;
         out_op_a_q <= '0;
         out_op_b_q <= '0;
         out_rd_q   <= '0;
         out_wr_q   <= 1'b0;
      end else if (move) begin
         out_v_q    <= 1'b1;
         out_op_a_q <= op_a_d;
         out_op_b_q <= op_b_d;
         out_rd_q   <= rd_rd_q;
         out_wr_q   <= rd_wr_q;
      end else if (out_ready) begin
         out_v_q <= 1'b0;
      end
   end

   assign out_valid = out_v_q;
   assign out_op_a  = out_op_a_q;
   assign out_op_b  = out_op_b_q;
   assign out_rd    = out_rd_q;
   assign out_wr    = out_wr_q;

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch with a
// behavioural 32x16 register file (read data registered, write-then-read
// in one cycle returns the old value).
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs_a, in_rs_b, in_rd;
   logic        in_use_a, in_use_b, in_wr;
   logic        rf_r_en_a, rf_r_en_b;
   logic [4:0]  rf_r_idx_a, rf_r_idx_b;
   logic [15:0] rf_r_data_a, rf_r_data_b;
   logic        wb_valid;
   logic [4:0]  wb_idx;
   logic [15:0] wb_data;
   logic        out_valid, out_ready;
   logic [15:0] out_op_a, out_op_b;
   logic [4:0]  out_rd;
   logic        out_wr;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [15:0] rf_mem [32];

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
      .in_use_a(in_use_a), .in_use_b(in_use_b),
      .in_rd(in_rd), .in_wr(in_wr),
      .rf_r_en_a(rf_r_en_a), .rf_r_en_b(rf_r_en_b),
      .rf_r_idx_a(rf_r_idx_a), .rf_r_idx_b(rf_r_idx_b),
      .rf_r_data_a(rf_r_data_a), .rf_r_data_b(rf_r_data_b),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op_a(out_op_a), .out_op_b(out_op_b),
      .out_rd(out_rd), .out_wr(out_wr)
   );

   // Register file model
   always @(posedge clk) begin
      if (rf_r_en_a) rf_r_data_a <= rf_mem[rf_r_idx_a];
      if (rf_r_en_b) rf_r_data_b <= rf_mem[rf_r_idx_b];
      if (wb_valid)  rf_mem[wb_idx] <= wb_data;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [4:0] ra, input logic ua,
                        input logic [4:0] rb, input logic ub,
                        input logic [4:0] rd, input logic wr);
      in_valid = v; in_rs_a = ra; in_use_a = ua; in_rs_b = rb; in_use_b = ub;
      in_rd = rd; in_wr = wr;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      out_ready = 1'b1; wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
      tick(); tick(); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_op_a !== 16'h0 || out_op_b !== 16'h0) $display("FAIL reset_ops got %h/%h exp 0/0", out_op_a, out_op_b); else pass_cnt++;
      total_cnt++; if (out_rd !== 5'd0 || out_wr !== 1'b0) $display("FAIL reset_rd_wr got %0d/%b exp 0/0", out_rd, out_wr); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
      tick(); reset = 1'b1;
   endtask

   task automatic test_basic();
      tick(); drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b exp 1", in_ready); else pass_cnt++;
      tick(); drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", out_valid); else pass_cnt++;
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_op_a !== 16'h1111 || out_op_b !== 16'h2222) $display("FAIL basic_ops got %h/%h exp 1111/2222", out_op_a, out_op_b); else pass_cnt++;
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %b exp 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_a [4] = '{16'hA00A, 16'hA00B, 16'hA00C, 16'hA00D};
      logic [15:0] exp_b [4] = '{16'hA014, 16'hA015, 16'hA016, 16'hA017};
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c < 4) drive(1'b1, 5'(10 + c), 1'b1, 5'(20 + c), 1'b1, 5'(c + 1), 1'b0);
         else       drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
         #1;
         if (c < 4) begin
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b exp 1", c, in_ready); else pass_cnt++;
         end
         if (c >= 2) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_rd !== 5'(c - 1) || out_op_a !== exp_a[c-2] || out_op_b !== exp_b[c-2])
               $display("FAIL stream_out[%0d] got v=%b rd=%0d %h/%h exp v=1 rd=%0d %h/%h",
                        c - 2, out_valid, out_rd, out_op_a, out_op_b, c - 1, exp_a[c-2], exp_b[c-2]);
            else pass_cnt++;
         end
      end
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_raw();
      tick(); drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL raw_wr_accept got %b exp 1", in_ready); else pass_cnt++;
      tick(); drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL raw_stall0 got %b exp 0", in_ready); else pass_cnt++;
      tick(); #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL raw_stall1 got %b exp 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_wr !== 1'b1) $display("FAIL raw_wr_out got v=%b rd=%0d wr=%b exp 1/5/1", out_valid, out_rd, out_wr); else pass_cnt++;
      tick(); wb_valid = 1'b1; wb_idx = 5'd5; wb_data = 16'hBEEF; #1;
`ifdef OPFETCH_WB_BYPASS_EN
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL raw_bypass_ready got %b exp 1", in_ready); else pass_cnt++;
      tick(); wb_valid = 1'b0; in_valid = 1'b0;
`else
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL raw_wb_cycle_stall got %b exp 0", in_ready); else pass_cnt++;
      tick(); wb_valid = 1'b0; #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL raw_after_wb_ready got %b exp 1", in_ready); else pass_cnt++;
      tick(); in_valid = 1'b0;
`endif
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b1 || out_op_a !== 16'hBEEF || out_op_b !== 16'h0) $display("FAIL raw_operand got v=%b %h/%h exp 1 BEEF/0000", out_valid, out_op_a, out_op_b); else pass_cnt++;
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      tick(); drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_accept_a got %b exp 1", in_ready); else pass_cnt++;
      tick(); drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_accept_b got %b exp 1", in_ready); else pass_cnt++;
      for (int c = 0; c < 3; c++) begin
         tick(); drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0); #1;
         total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", c, in_ready); else pass_cnt++;
         total_cnt++;
         if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_op_a !== 16'hA00A || out_op_b !== 16'h0)
            $display("FAIL bp_hold[%0d] got v=%b rd=%0d %h/%h exp 1/1 A00A/0000", c, out_valid, out_rd, out_op_a, out_op_b);
         else pass_cnt++;
      end
      tick(); in_valid = 1'b0; out_ready = 1'b1; #1;
      total_cnt++; if (out_rd !== 5'd1 || out_op_a !== 16'hA00A) $display("FAIL bp_release_first got rd=%0d %h exp 1 A00A", out_rd, out_op_a); else pass_cnt++;
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_op_a !== 16'hA00B) $display("FAIL bp_release_second got v=%b rd=%0d %h exp 1/2 A00B", out_valid, out_rd, out_op_a); else pass_cnt++;
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_waw();
      tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL waw_first got %b exp 1", in_ready); else pass_cnt++;
      tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL waw_stall0 got %b exp 0", in_ready); else pass_cnt++;
      tick(); #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL waw_stall1 got %b exp 0", in_ready); else pass_cnt++;
      tick(); wb_valid = 1'b1; wb_idx = 5'd7; wb_data = 16'h7777; #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL waw_wb_cycle got %b exp 0", in_ready); else pass_cnt++;
      tick(); wb_valid = 1'b0; #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL waw_after_wb got %b exp 1", in_ready); else pass_cnt++;
      tick(); drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL waw_rebusy got %b exp 0", in_ready); else pass_cnt++;
      tick(); in_valid = 1'b0; wb_valid = 1'b1; wb_idx = 5'd7; wb_data = 16'h7777; #1;
      total_cnt++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_wr !== 1'b1) $display("FAIL waw_out got v=%b rd=%0d wr=%b exp 1/7/1", out_valid, out_rd, out_wr); else pass_cnt++;
      tick(); wb_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
      tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_fill got %b exp 1", in_ready); else pass_cnt++;
      tick(); in_valid = 1'b0; #1;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_full got %b exp 1", out_valid); else pass_cnt++;
      reset = 1'b0; #1;
      total_cnt++; if (out_valid !== 1'b0 || out_wr !== 1'b0 || out_rd !== 5'd0) $display("FAIL rst_async got v=%b wr=%b rd=%0d exp 0/0/0", out_valid, out_wr, out_rd); else pass_cnt++;
      tick(); reset = 1'b1; out_ready = 1'b1;
      drive(1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_no_stall got %b exp 1", in_ready); else pass_cnt++;
      tick(); in_valid = 1'b0;
      tick(); #1;
      total_cnt++; if (out_valid !== 1'b1 || out_op_a !== 16'hA002 || out_op_b !== 16'hA009) $display("FAIL rst_read got v=%b %h/%h exp 1 A002/A009", out_valid, out_op_a, out_op_b); else pass_cnt++;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 16'hA000 | 16'(i);
      rf_mem[3] = 16'h1111;
      rf_mem[4] = 16'h2222;
      rf_r_data_a = '0;
      rf_r_data_b = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_raw();
      test_backpressure();
      test_waw();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_operand_fetch
